// File: rtl/pc_gen.sv
// Program counter generator with a HOLD/REQ/EXEC fetch handshake.
// Holds the fetch address, offers it to the fetch unit with valid/ready, and
// computes the next PC when the executing instruction commits (sequential,
// branch, jal, jalr, trap, mret). An external flush redirects at any time.
//
// Handshake: while in REQ, req_valid is held high and pc is held stable until
// the cycle where req_valid && req_ready are both high at a rising edge; that
// edge is the transfer and the FSM moves to EXEC. The only exception is a
// flush, which replaces pc while keeping req_valid high.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h8000_0000),
  parameter int              C_EXT     = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] pc,
  input  logic            commit,
  input  logic            is_c,
  input  logic            is_b,
  input  logic [2:0]      b_type,
  input  logic            cmp,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] pc_link,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP2 = XLEN'(2);
  localparam logic [XLEN-1:0] STEP4 = XLEN'(4);

  state_t          cur_state;
  logic            use_c;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] xfer_tgt;
  logic            xfer;
  logic            tgt_bad;

  assign state    = cur_state;
  assign use_c    = (C_EXT != 0) && is_c;
  assign pc_link  = pc + (use_c ? STEP2 : STEP4);
  assign jalr_sum = rs1_data + imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign rel_tgt  = pc + imm;

  // Branch resolution: odd codes take on cmp=1, their complements on cmp=0.
  always_comb begin
    taken = 1'b0;
    case (b_type)
      3'b001:  taken = cmp;
      3'b010:  taken = ~cmp;
      3'b011:  taken = cmp;
      3'b100:  taken = ~cmp;
      3'b101:  taken = cmp;
      3'b110:  taken = ~cmp;
      default: taken = 1'b0;
    endcase
  end

  // Next-PC selection in priority order; xfer marks control-transfer targets
  // that are subject to the alignment check.
  always_comb begin
    next_pc  = pc_link;
    xfer_tgt = '0;
    xfer     = 1'b0;
    if (trap) begin
      next_pc = trap_vec;
    end else if (is_mret) begin
      next_pc = mepc;
    end else if (is_jalr) begin
      next_pc  = jalr_tgt;
      xfer_tgt = jalr_tgt;
      xfer     = 1'b1;
    end else if (is_jal || (is_b && taken)) begin
      next_pc  = rel_tgt;
      xfer_tgt = rel_tgt;
      xfer     = 1'b1;
    end
  end

  // With compressed support only byte alignment is illegal; otherwise the
  // target must be word aligned.
  always_comb begin
    if (C_EXT != 0) tgt_bad = xfer & xfer_tgt[0];
    else            tgt_bad = xfer & (xfer_tgt[1] | xfer_tgt[0]);
  end

  // Fetch FSM with registered req_valid, pc and misalign reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state     <= S_HOLD;
      req_valid     <= 1'b0;
      pc            <= RESET_VEC;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= 1'b0;
      if (flush) begin
        pc        <= flush_pc;
        cur_state <= S_REQ;
        req_valid <= 1'b1;
      end else begin
        case (cur_state)
          S_HOLD: begin
            cur_state <= S_REQ;
            req_valid <= 1'b1;
          end
          S_REQ: begin
            if (req_ready) begin
              cur_state <= S_EXEC;
              req_valid <= 1'b0;
            end
          end
          S_EXEC: begin
            if (commit) begin
              cur_state <= S_REQ;
              req_valid <= 1'b1;
              if (tgt_bad) begin
                pc            <= trap_vec;
                misalign      <= 1'b1;
                misalign_addr <= xfer_tgt;
              end else begin
                pc <= next_pc;
              end
            end
          end
          default: begin
            cur_state <= S_HOLD;
            req_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (word-only and compressed-enabled) share all
// inputs and move through the handshake in lockstep; each commit pushes the
// expected {misalign, pc} per instance to a queue that is popped after the edge.
module tb_pc_gen;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [31:0] RVEC   = 32'h8000_0000;

  logic        clk, rst;
  logic        req_ready, commit, is_c, is_b, cmp, is_jal, is_jalr;
  logic [2:0]  b_type;
  logic [31:0] imm, rs1_data, trap_vec, mepc, flush_pc;
  logic        trap, is_mret, flush;

  logic        req_valid, misalign;
  logic [31:0] pc, pc_link, misalign_addr;
  logic [1:0]  state;
  logic        req_valid_c, misalign_c;
  logic [31:0] pc_c, pc_link_c, misalign_addr_c;
  logic [1:0]  state_c;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_c_q[$];

  logic [31:0] m_pc, m_pc_c, m_maddr, m_maddr_c;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .C_EXT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .pc(pc),
    .commit(commit), .is_c(is_c), .is_b(is_b), .b_type(b_type), .cmp(cmp),
    .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .rs1_data(rs1_data),
    .trap(trap), .trap_vec(trap_vec), .is_mret(is_mret), .mepc(mepc),
    .flush(flush), .flush_pc(flush_pc), .pc_link(pc_link), .misalign(misalign),
    .misalign_addr(misalign_addr), .state(state)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .C_EXT(1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready), .pc(pc_c),
    .commit(commit), .is_c(is_c), .is_b(is_b), .b_type(b_type), .cmp(cmp),
    .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm), .rs1_data(rs1_data),
    .trap(trap), .trap_vec(trap_vec), .is_mret(is_mret), .mepc(mepc),
    .flush(flush), .flush_pc(flush_pc), .pc_link(pc_link_c), .misalign(misalign_c),
    .misalign_addr(misalign_addr_c), .state(state_c)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, elapsed=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

  // Reference next-PC model for one instance.
  function automatic void model(input logic [31:0] cur, input bit cext,
                                output logic [31:0] nxt, output logic mis,
                                output logic [31:0] tgt);
    logic [31:0] link;
    bit tk;
    link = cur + ((cext && is_c) ? 32'd2 : 32'd4);
    tk = is_b && (((b_type == 3'd1 || b_type == 3'd3 || b_type == 3'd5) && cmp) ||
                  ((b_type == 3'd2 || b_type == 3'd4 || b_type == 3'd6) && !cmp));
    mis = 1'b0;
    tgt = 32'h0;
    if (trap) nxt = trap_vec;
    else if (is_mret) nxt = mepc;
    else if (is_jalr || is_jal || tk) begin
      tgt = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (cur + imm);
      if (cext ? tgt[0] : (tgt[1:0] != 2'b00)) begin
        mis = 1'b1;
        nxt = trap_vec;
      end else begin
        nxt = tgt;
      end
    end else nxt = link;
  endfunction

  task automatic clear_ins();
    commit = 0; is_c = 0; is_b = 0; b_type = 3'd0; cmp = 0; is_jal = 0; is_jalr = 0;
    imm = 32'h0; rs1_data = 32'h0; trap = 0; is_mret = 0; flush = 0; flush_pc = 32'h0;
  endtask

  // Wait (bounded) for a request, check its address, then accept it.
  task automatic fetch(input string name);
    int n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (n == 20) begin
      n_err++;
      $display("FAIL %s_req_timeout: req_valid=%b after %0d cycles, required 1", name, req_valid, n);
    end
    n_cmp++;
    if (pc !== m_pc || pc_c !== m_pc_c) begin
      n_err++;
      $display("FAIL %s_req_pc: pc=%h pc_c=%h, required %h %h", name, pc, pc_c, m_pc, m_pc_c);
    end
    req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0;
    n_cmp++;
    if (req_valid !== 1'b0 || state !== ST_EXEC || state_c !== ST_EXEC) begin
      n_err++;
      $display("FAIL %s_exec: req_valid=%b state=%0d state_c=%0d, required 0 %0d", name, req_valid, state, state_c, ST_EXEC);
    end
  endtask

  // Commit the instruction described by the current inputs and score it.
  task automatic do_commit(input string name);
    logic [31:0] n0, t0, n1, t1;
    logic m0, m1;
    logic [32:0] e;
    fetch(name);
    commit = 1;
    model(m_pc, 1'b0, n0, m0, t0);
    model(m_pc_c, 1'b1, n1, m1, t1);
    exp_q.push_back({m0, n0});
    exp_c_q.push_back({m1, n1});
    #1;
    n_cmp++;
    if (pc_link !== m_pc + 32'd4 || pc_link_c !== m_pc_c + (is_c ? 32'd2 : 32'd4)) begin
      n_err++;
      $display("FAIL %s_link: pc_link=%h pc_link_c=%h, required %h %h", name, pc_link, pc_link_c,
               m_pc + 32'd4, m_pc_c + (is_c ? 32'd2 : 32'd4));
    end
    @(posedge clk); #1;
    clear_ins();
    e = exp_q.pop_front();
    if (e[32]) m_maddr = t0;
    m_pc = e[31:0];
    n_cmp++;
    if ({misalign, pc} !== e) begin
      n_err++;
      $display("FAIL %s_pc: misalign=%b pc=%h, required %b %h", name, misalign, pc, e[32], e[31:0]);
    end
    e = exp_c_q.pop_front();
    if (e[32]) m_maddr_c = t1;
    m_pc_c = e[31:0];
    n_cmp++;
    if ({misalign_c, pc_c} !== e) begin
      n_err++;
      $display("FAIL %s_pc_c: misalign=%b pc=%h, required %b %h", name, misalign_c, pc_c, e[32], e[31:0]);
    end
    n_cmp++;
    if (misalign_addr !== m_maddr || misalign_addr_c !== m_maddr_c) begin
      n_err++;
      $display("FAIL %s_maddr: %h %h, required %h %h", name, misalign_addr, misalign_addr_c, m_maddr, m_maddr_c);
    end
  endtask

  // Redirect both instances from the REQ state (req_ready low) via flush.
  task automatic set_pc(input logic [31:0] addr);
    flush = 1; flush_pc = addr;
    @(posedge clk); #1;
    flush = 0;
    m_pc = addr; m_pc_c = addr;
    n_cmp++;
    if (pc !== addr || pc_c !== addr || req_valid !== 1'b1 || state !== ST_REQ) begin
      n_err++;
      $display("FAIL flush_set: pc=%h pc_c=%h req_valid=%b state=%0d, required %h %h 1 %0d",
               pc, pc_c, req_valid, state, addr, addr, ST_REQ);
    end
  endtask

  task automatic test_reset();
    rst = 1; req_ready = 0; clear_ins();
    #1;
    n_cmp++;
    if (pc !== RVEC || req_valid !== 1'b0 || misalign !== 1'b0 || misalign_addr !== 32'h0 || state !== ST_HOLD) begin
      n_err++;
      $display("FAIL reset_state: pc=%h rv=%b mis=%b maddr=%h st=%0d, required %h 0 0 0 0",
               pc, req_valid, misalign, misalign_addr, state, RVEC);
    end
    repeat (3) @(posedge clk);
    #1; rst = 0; req_ready = 1;
    n_cmp++;
    if (state !== ST_HOLD || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: state=%0d req_valid=%b, required %0d 0", state, req_valid, ST_HOLD);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_valid !== 1'b1 || pc !== RVEC || state !== ST_REQ) begin
      n_err++;
      $display("FAIL reset_first_req: rv=%b pc=%h st=%0d, required 1 %h %0d", req_valid, pc, state, RVEC, ST_REQ);
    end
    @(posedge clk); #1;
    req_ready = 0;
    n_cmp++;
    if (req_valid !== 1'b0 || state !== ST_EXEC) begin
      n_err++;
      $display("FAIL reset_accept: rv=%b st=%0d, required 0 %0d", req_valid, state, ST_EXEC);
    end
    // Complete this instruction so later tests start from REQ.
    commit = 1;
    @(posedge clk); #1;
    clear_ins();
    m_pc = RVEC + 32'd4; m_pc_c = RVEC + 32'd4; m_maddr = 0; m_maddr_c = 0;
    n_cmp++;
    if (pc !== 32'h8000_0004 || pc_c !== 32'h8000_0004) begin
      n_err++;
      $display("FAIL reset_first_commit: pc=%h pc_c=%h, required 80000004", pc, pc_c);
    end
  endtask

  task automatic test_sequential();
    do_commit("seq_w1");
    n_cmp++;
    if (pc !== 32'h8000_0008) begin
      n_err++;
      $display("FAIL seq_w1_abs: pc=%h, required 80000008", pc);
    end
    is_c = 1; do_commit("seq_c1");
    is_c = 1; do_commit("seq_c2");
    n_cmp++;
    if (pc !== 32'h8000_0010 || pc_c !== 32'h8000_000C) begin
      n_err++;
      $display("FAIL seq_c_abs: pc=%h pc_c=%h, required 80000010 8000000c", pc, pc_c);
    end
  endtask

  task automatic test_branch();
    set_pc(32'h8000_0010);
    is_b = 1; b_type = 3'b010; cmp = 0; imm = -32'sd8; do_commit("bne_taken");
    n_cmp++;
    if (pc !== 32'h8000_0008) begin
      n_err++;
      $display("FAIL bne_abs: pc=%h, required 80000008", pc);
    end
    set_pc(32'h8000_0010);
    is_b = 1; b_type = 3'b001; cmp = 0; imm = -32'sd8; do_commit("beq_not_taken");
    n_cmp++;
    if (pc !== 32'h8000_0014) begin
      n_err++;
      $display("FAIL beq_abs: pc=%h, required 80000014", pc);
    end
    for (int bt = 0; bt < 8; bt++) begin
      for (int c = 0; c < 2; c++) begin
        set_pc(32'h8000_1000 + 32'($urandom_range(0, 255)) * 32'd4);
        is_b = 1; b_type = 3'(bt); cmp = c[0];
        imm = 32'($urandom_range(0, 511)) * 32'd4 - 32'd1024;
        do_commit("branch_sweep");
      end
    end
    // Taken branch to a halfword target: illegal only without compressed support.
    set_pc(32'h8000_2000);
    is_b = 1; b_type = 3'b101; cmp = 1; imm = 32'd2; do_commit("branch_half");
    // Wrap-around of the relative target.
    set_pc(32'hFFFF_FFF8);
    is_jal = 1; imm = 32'd16; do_commit("jal_wrap");
    n_cmp++;
    if (pc !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL jal_wrap_abs: pc=%h, required 00000008", pc);
    end
  endtask

  task automatic test_jump();
    set_pc(32'h8000_0040);
    is_jalr = 1; rs1_data = 32'h8000_0101; imm = 32'd4; do_commit("jalr");
    n_cmp++;
    if (pc !== 32'h8000_0104) begin
      n_err++;
      $display("FAIL jalr_abs: pc=%h, required 80000104", pc);
    end
    set_pc(32'h8000_0050);
    is_jal = 1; imm = 32'd6; do_commit("jal_mis");
    n_cmp++;
    if (misalign !== 1'b1 || misalign_addr !== 32'h8000_0056 || pc !== trap_vec || pc_c !== 32'h8000_0056) begin
      n_err++;
      $display("FAIL jal_mis_abs: mis=%b maddr=%h pc=%h pc_c=%h, required 1 80000056 %h 80000056",
               misalign, misalign_addr, pc, pc_c, trap_vec);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (misalign !== 1'b0 || misalign_addr !== 32'h8000_0056) begin
      n_err++;
      $display("FAIL mis_pulse: mis=%b maddr=%h, required 0 80000056", misalign, misalign_addr);
    end
    is_jalr = 1; rs1_data = 32'h8000_0003; imm = 32'd0; do_commit("jalr_mis");
  endtask

  task automatic test_trap_mret();
    set_pc(32'h8000_0300);
    trap_vec = 32'h8000_0403;
    trap = 1; is_jal = 1; imm = 32'd6; do_commit("trap_over_jal");
    n_cmp++;
    if (pc !== 32'h8000_0403 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL trap_abs: pc=%h mis=%b, required 80000403 0", pc, misalign);
    end
    trap_vec = 32'h8000_0400;
    is_mret = 1; is_jalr = 1; rs1_data = 32'h1; do_commit("mret");
    n_cmp++;
    if (pc !== mepc) begin
      n_err++;
      $display("FAIL mret_abs: pc=%h, required %h", pc, mepc);
    end
    // Commit while waiting in REQ must be ignored.
    commit = 1; is_jal = 1; imm = 32'h40;
    @(posedge clk); #1;
    clear_ins();
    n_cmp++;
    if (pc !== m_pc || state !== ST_REQ || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL commit_in_req: pc=%h st=%0d rv=%b, required %h %0d 1", pc, state, req_valid, m_pc, ST_REQ);
    end
  endtask

  task automatic test_flush_reset();
    // Flush beats a same-cycle commit.
    fetch("flush_commit");
    commit = 1; is_jal = 1; imm = 32'h80; flush = 1; flush_pc = 32'h8000_0A00;
    @(posedge clk); #1;
    clear_ins();
    m_pc = 32'h8000_0A00; m_pc_c = 32'h8000_0A00;
    n_cmp++;
    if (pc !== 32'h8000_0A00 || state !== ST_REQ || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_over_commit: pc=%h st=%0d rv=%b, required 80000a00 %0d 1", pc, state, req_valid, ST_REQ);
    end
    // Flush while a request is pending and unaccepted.
    @(posedge clk); #1;
    set_pc(32'h8000_0ABC);
    fetch("flush_then_rst");
    rst = 1;
    #1;
    n_cmp++;
    if (pc !== RVEC || req_valid !== 1'b0 || state !== ST_HOLD || misalign_addr !== 32'h0 || pc_c !== RVEC) begin
      n_err++;
      $display("FAIL rst_mid_exec: pc=%h rv=%b st=%0d maddr=%h pc_c=%h, required %h 0 %0d 0 %h",
               pc, req_valid, state, misalign_addr, pc_c, RVEC, ST_HOLD, RVEC);
    end
    @(posedge clk); #1;
    rst = 0;
    m_pc = RVEC; m_pc_c = RVEC; m_maddr = 0; m_maddr_c = 0;
    n_cmp++;
    if (req_valid !== 1'b0 || state !== ST_HOLD) begin
      n_err++;
      $display("FAIL rst_release_hold: rv=%b st=%0d, required 0 %0d", req_valid, state, ST_HOLD);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_valid !== 1'b1 || pc !== RVEC) begin
      n_err++;
      $display("FAIL rst_release_req: rv=%b pc=%h, required 1 %h", req_valid, pc, RVEC);
    end
    do_commit("post_reset");
  endtask

  initial begin
    trap_vec = 32'h8000_0400;
    mepc     = 32'h8000_0200;
    m_pc = RVEC; m_pc_c = RVEC; m_maddr = 0; m_maddr_c = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_trap_mret();
    test_flush_reset();
    n_cmp++;
    if (exp_q.size() != 0 || exp_c_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: left=%0d %0d, required 0 0", exp_q.size(), exp_c_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter RESET_VEC, default 32'h8000_0000, PC value loaded on reset.
REQ-003 Parameter C_EXT, default 0, 1 = 2-byte alignment allowed and compressed (+2) sequencing enabled.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  out  1  fetch request valid.
REQ-007 req_ready  in  1  fetch unit accepts request.
REQ-008 pc  out  XLEN  current PC / fetch address.
REQ-009 commit  in  1  instruction at pc finished, next-PC inputs valid this cycle.
REQ-010 is_c  in  1  committed instruction is 16-bit (ignored when C_EXT=0).
REQ-011 is_b, b_type[2:0], cmp  in  1/3/1  branch flag, type (001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU), comparator result.
REQ-012 is_jal, is_jalr  in  1  jump flags.
REQ-013 imm, rs1_data  in  XLEN  immediate, rs1 value.
REQ-014 trap, trap_vec  in  1/XLEN  exception request, handler address.
REQ-015 is_mret, mepc  in  1/XLEN  return-from-trap, return address.
REQ-016 flush, flush_pc  in  1/XLEN  external redirect.
REQ-017 pc_link  out  XLEN  link value: pc+2 if C_EXT and is_c, else pc+4 (combinational).
REQ-018 misalign  out  1  one-cycle pulse, misaligned target detected.
REQ-019 misalign_addr  out  XLEN  offending target, held until next misalign.

Function
REQ-020 States: HOLD, REQ, EXEC; HOLD entered on reset.
REQ-021 HOLD: req_valid=0; next cycle -> REQ.
REQ-022 REQ: req_valid=1, pc stable; req_valid&req_ready -> EXEC; req_valid SHALL not drop before acceptance.
REQ-023 EXEC: req_valid=0; commit -> pc updated to next PC at same edge, state -> REQ.
REQ-024 Branch taken: BEQ/BLT/BLTU when cmp=1; BNE/BGE/BGEU when cmp=0; other b_type codes never taken.
REQ-025 Next-PC priority at commit: trap -> trap_vec; is_mret -> mepc; is_jalr -> (rs1_data+imm)&~1; is_jal or taken branch -> pc+imm; else pc_link.
REQ-026 All additions modulo 2^XLEN, wrap-around silent.
REQ-027 Alignment: target needing bit1 or bit0 =1 (C_EXT=0) or bit0 =1 (C_EXT=1) is misaligned; applies to jal/jalr/branch targets only.
REQ-028 Misaligned target: pc <= trap_vec, misalign pulses 1 cycle, misalign_addr <= target.
REQ-029 trap_vec/mepc/flush_pc loaded unchecked.
REQ-030 flush in any state: pc <= flush_pc, state -> REQ next cycle; overrides commit in same cycle; in REQ abandons pending request (req_valid stays 1 with new pc).
REQ-031 commit outside EXEC ignored.
REQ-032 Single-cycle next-PC latency: new pc visible the cycle after commit edge.

Reset
REQ-033 rst asserted: immediately pc=RESET_VEC, state=HOLD, req_valid=0, misalign=0, misalign_addr=0.
REQ-034 Reset mid-handshake or mid-EXEC discards all pending state; first request after release at RESET_VEC after one HOLD cycle.

Verification
REQ-035 Reset release, req_ready=1 -> HOLD 1 cycle, req_valid=1 with pc=8000_0000, accepted, EXEC.
REQ-036 Sequential commits, is_c=0 -> pc 8000_0000, 8000_0004, 8000_0008; C_EXT=1 with is_c=1 -> +2 steps.
REQ-037 BNE cmp=0 imm=-8 at 8000_0010 -> pc 8000_0008; BEQ cmp=0 -> 8000_0014.
REQ-038 jalr rs1=8000_0101 imm=4 -> pc 8000_0104; jal imm=6 with C_EXT=0 -> misalign pulse, misalign_addr=pc+6, pc=trap_vec.
REQ-039 Commit with trap=1 and is_jal=1 together -> pc=trap_vec; mret -> pc=mepc.
REQ-040 flush during REQ with req_ready=0, then rst mid-EXEC -> pc=flush_pc with req_valid held; then pc=8000_0000, req_valid=0 immediately.
